// File: rtl/timer_pkg.sv
// timer_pkg: channel mode and FSM state types shared by the multi_channel_timer files
package timer_pkg;
    typedef enum logic [1:0] {
        MODE_OFF      = 2'b00,
        MODE_ONE_SHOT = 2'b01,
        MODE_PERIODIC = 2'b10,
        MODE_PWM      = 2'b11
    } mode_t;
    typedef enum logic {CH_IDLE, CH_RUN} ch_state_t;
endpackage

// File: rtl/multi_channel_timer_if.sv
// multi_channel_timer_if: config/control/status bundle of the timer block
// TIMER_IRQ_STICKY_EN adds the sticky interrupt clear/status/summary signals
interface multi_channel_timer_if #(parameter int NUM_CH = 4, parameter int CNT_W = 32);
    localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [1:0]        cfg_mode;
    logic [CNT_W-1:0]  cfg_load;
    logic [CNT_W-1:0]  cfg_cmp;
    logic [NUM_CH-1:0] start;
    logic [NUM_CH-1:0] stop;
    logic [NUM_CH-1:0] busy;
    logic [NUM_CH-1:0] time_out;
    logic [NUM_CH-1:0] pwm_out;
    logic [CNT_W-1:0]  cnt_rd_data;
`ifdef TIMER_IRQ_STICKY_EN
    logic [NUM_CH-1:0] irq_clr;
    logic [NUM_CH-1:0] irq_status;
    logic              irq;
`endif
    modport master (
        output cfg_we, cfg_ch, cfg_mode, cfg_load, cfg_cmp, start, stop,
`ifdef TIMER_IRQ_STICKY_EN
        output irq_clr,
        input  irq_status, irq,
`endif
        input  busy, time_out, pwm_out, cnt_rd_data
    );
    modport slave (
        input  cfg_we, cfg_ch, cfg_mode, cfg_load, cfg_cmp, start, stop,
`ifdef TIMER_IRQ_STICKY_EN
        input  irq_clr,
        output irq_status, irq,
`endif
        output busy, time_out, pwm_out, cnt_rd_data
    );
endinterface

// File: rtl/timer_channel.sv
// timer_channel: one down-counting channel with shadow/active config, IDLE/RUN FSM and outputs
// TIMER_IRQ_STICKY_EN adds a sticky interrupt status bit set by time_out
module timer_channel
    import timer_pkg::*;
#(parameter int CNT_W = 32) (
    input  logic             prescaled_clk,
    input  logic             reset_n,
    input  logic             i_we,
    input  mode_t            i_mode,
    input  logic [CNT_W-1:0] i_load,
    input  logic [CNT_W-1:0] i_cmp,
    input  logic             i_start,
    input  logic             i_stop,
`ifdef TIMER_IRQ_STICKY_EN
    input  logic             i_irq_clr,
    output logic             o_irq_status,
`endif
    output logic             o_busy,
    output logic             o_time_out,
    output logic             o_pwm,
    output logic [CNT_W-1:0] o_cnt
);
    ch_state_t        r_state, w_next;
    mode_t            r_sh_mode, r_act_mode;
    logic [CNT_W-1:0] r_sh_load, r_sh_cmp, r_act_cmp, r_cnt;
    logic             r_time_out;
    logic             w_run, w_zero, w_start_ok, w_active, w_expire, w_load;
    assign w_run      = r_state == CH_RUN;
    assign w_zero     = r_cnt == '0;
    assign w_start_ok = i_start && !i_stop && r_sh_mode != MODE_OFF;
    assign w_active   = w_run && !i_stop && !w_start_ok;
    assign w_expire   = w_active && w_zero;
    // start or a periodic/PWM expiry copies shadow into active; shadow written this cycle lands after
    assign w_load     = w_start_ok || (w_expire && r_act_mode != MODE_ONE_SHOT);
    always_ff @(posedge prescaled_clk or negedge reset_n)
        if (!reset_n) r_state <= CH_IDLE;
        else          r_state <= w_next;
    always_comb begin
        w_next = r_state;
        if (!w_run)          w_next = w_start_ok ? CH_RUN : CH_IDLE;
        else if (i_stop)     w_next = CH_IDLE;
        else if (w_start_ok) w_next = CH_RUN;
        else if (w_zero)     w_next = (r_act_mode == MODE_ONE_SHOT || r_sh_mode == MODE_OFF) ? CH_IDLE : CH_RUN;
    end
    always_comb begin
        o_busy     = w_run;
        o_time_out = r_time_out;
        o_pwm      = w_run && r_act_mode == MODE_PWM && r_cnt < r_act_cmp;
        o_cnt      = r_cnt;
    end
    always_ff @(posedge prescaled_clk or negedge reset_n)
        if (!reset_n) begin
            r_sh_mode  <= MODE_OFF;
            r_sh_load  <= '0;
            r_sh_cmp   <= '0;
            r_act_mode <= MODE_OFF;
            r_act_cmp  <= '0;
            r_cnt      <= '0;
            r_time_out <= 1'b0;
        end else begin
            if (i_we) begin
                r_sh_mode <= i_mode;
                r_sh_load <= i_load;
                r_sh_cmp  <= i_cmp;
            end
            if (w_load) begin
                r_act_mode <= r_sh_mode;
                r_act_cmp  <= r_sh_cmp;
            end
            r_cnt      <= w_load ? r_sh_load : (w_active && !w_zero) ? r_cnt - CNT_W'(1) : r_cnt;
            r_time_out <= w_expire;
        end
`ifdef TIMER_IRQ_STICKY_EN
    logic r_irq_status;
    always_ff @(posedge prescaled_clk or negedge reset_n)
        if (!reset_n) r_irq_status <= 1'b0;
        else          r_irq_status <= (r_irq_status && !i_irq_clr) || r_time_out;
    assign o_irq_status = r_irq_status;
`endif
endmodule

// File: rtl/multi_channel_timer.sv
// multi_channel_timer: NUM_CH independent timer channels behind one shared config write port
// TIMER_IRQ_STICKY_EN adds sticky per-channel irq_status and a combined irq
module multi_channel_timer
    import timer_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input logic                  prescaled_clk,
    input logic                  reset_n,
    multi_channel_timer_if.slave bus
);
    localparam int CH_W = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
    logic [CNT_W-1:0]  w_cnt [NUM_CH];
    logic [NUM_CH-1:0] w_busy, w_time_out, w_pwm;
`ifdef TIMER_IRQ_STICKY_EN
    logic [NUM_CH-1:0] w_irq_status;
    assign bus.irq_status = w_irq_status;
    assign bus.irq        = |w_irq_status;
`endif
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        timer_channel #(.CNT_W(CNT_W)) u_ch (
            .prescaled_clk(prescaled_clk),
            .reset_n      (reset_n),
            .i_we         (bus.cfg_we && bus.cfg_ch == CH_W'(g)),
            .i_mode       (mode_t'(bus.cfg_mode)),
            .i_load       (bus.cfg_load),
            .i_cmp        (bus.cfg_cmp),
            .i_start      (bus.start[g]),
            .i_stop       (bus.stop[g]),
`ifdef TIMER_IRQ_STICKY_EN
            .i_irq_clr    (bus.irq_clr[g]),
            .o_irq_status (w_irq_status[g]),
`endif
            .o_busy       (w_busy[g]),
            .o_time_out   (w_time_out[g]),
            .o_pwm        (w_pwm[g]),
            .o_cnt        (w_cnt[g])
        );
    end
    assign bus.busy     = w_busy;
    assign bus.time_out = w_time_out;
    assign bus.pwm_out  = w_pwm;
    // selects beyond NUM_CH read back zero
    always_comb begin
        bus.cnt_rd_data = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (bus.cfg_ch == CH_W'(i)) bus.cnt_rd_data = w_cnt[i];
    end
endmodule

// File: tb/tb_multi_channel_timer.sv
// tb_multi_channel_timer: directed and random stimulus against a segment-based timer model
// TIMER_IRQ_STICKY_EN also checks the sticky interrupt outputs
module tb_multi_channel_timer;
    localparam int N = 3;
    localparam int W = 32;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    multi_channel_timer_if #(.NUM_CH(N), .CNT_W(W)) bus();
    multi_channel_timer #(.NUM_CH(N), .CNT_W(W)) dut (.prescaled_clk(clk), .reset_n(rst_n), .bus(bus));
    int tests = 0;
    int fails = 0;
    longint cyc = 0;
    // a running channel is a segment: loaded with ld at edge seg, so count = ld - elapsed edges
    int sh_mode[N], sh_load[N], sh_cmp[N], mode[N], ld[N], cmp[N], frz[N];
    longint seg[N];
    bit run[N], to[N], st[N];
    function automatic int cnt_of(int i);
        return run[i] ? ld[i] - int'(cyc - seg[i]) : frz[i];
    endfunction
    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            sh_mode[i] = 0; sh_load[i] = 0; sh_cmp[i] = 0; mode[i] = 0; ld[i] = 0; cmp[i] = 0;
            frz[i] = 0; seg[i] = 0; run[i] = 0; to[i] = 0; st[i] = 0;
        end
    endtask
    task automatic model_edge();
        int c[N];
        bit ok;
        for (int i = 0; i < N; i++) c[i] = cnt_of(i);
        cyc++;
        for (int i = 0; i < N; i++) begin
            ok = bus.start[i] && !bus.stop[i] && sh_mode[i] != 0;
            to[i] = 0;
            if (run[i] && bus.stop[i]) begin
                run[i] = 0; frz[i] = c[i];
            end else if (ok) begin
                run[i] = 1; mode[i] = sh_mode[i]; cmp[i] = sh_cmp[i]; ld[i] = sh_load[i]; seg[i] = cyc;
            end else if (run[i] && c[i] == 0) begin
                to[i] = 1;
                if (mode[i] == 1) begin
                    run[i] = 0; frz[i] = 0;
                end else begin
                    mode[i] = sh_mode[i]; cmp[i] = sh_cmp[i]; ld[i] = sh_load[i]; seg[i] = cyc;
                    if (sh_mode[i] == 0) begin run[i] = 0; frz[i] = sh_load[i]; end
                end
            end
`ifdef TIMER_IRQ_STICKY_EN
            st[i] = (st[i] && !bus.irq_clr[i]) || to[i];
`endif
            if (bus.cfg_we && int'(bus.cfg_ch) == i) begin
                sh_mode[i] = int'(bus.cfg_mode); sh_load[i] = int'(bus.cfg_load); sh_cmp[i] = int'(bus.cfg_cmp);
            end
        end
    endtask
    task automatic check_all();
        bit any;
        any = 0;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("busy%0d", i), 64'(bus.busy[i]), 64'(run[i]));
            chk($sformatf("time_out%0d", i), 64'(bus.time_out[i]), 64'(to[i]));
            chk($sformatf("pwm%0d", i), 64'(bus.pwm_out[i]), 64'(run[i] && mode[i] == 3 && cnt_of(i) < cmp[i]));
`ifdef TIMER_IRQ_STICKY_EN
            chk($sformatf("irq_status%0d", i), 64'(bus.irq_status[i]), 64'(st[i]));
`endif
            any = any || st[i];
        end
`ifdef TIMER_IRQ_STICKY_EN
        chk("irq", 64'(bus.irq), 64'(any));
`endif
        if (int'(bus.cfg_ch) < N) chk("cnt_rd", 64'(bus.cnt_rd_data), 64'(cnt_of(int'(bus.cfg_ch))));
    endtask
    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            check_all();
        end
    endtask
    task automatic wr(int ch, int m, int l, int c);
        bus.cfg_we = 1'b1; bus.cfg_ch = 2'(ch); bus.cfg_mode = 2'(m); bus.cfg_load = W'(l); bus.cfg_cmp = W'(c);
        tick();
        bus.cfg_we = 1'b0;
    endtask
    task automatic pulse(logic [N-1:0] s, logic [N-1:0] p);
        bus.start = s; bus.stop = p;
        tick();
        bus.start = '0; bus.stop = '0;
    endtask
    task automatic async_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        chk("rst_busy", 64'(bus.busy), 64'(0));
        #1 rst_n = 1'b1;
    endtask
    initial begin
        bus.cfg_we = 0; bus.cfg_ch = '0; bus.cfg_mode = '0; bus.cfg_load = '0; bus.cfg_cmp = '0;
        bus.start = '0; bus.stop = '0;
`ifdef TIMER_IRQ_STICKY_EN
        bus.irq_clr = '0;
`endif
        model_reset();
        #3 check_all();
        #4 rst_n = 1'b1;
        // one-shot ch0 load=5
        wr(0, 1, 5, 0);
        pulse(3'b001, 3'b000);
        tick(8);
        chk("oneshot_idle", 64'(bus.busy[0]), 64'(0));
        chk("oneshot_cnt", 64'(bus.cnt_rd_data), 64'(0));
        // periodic ch1 load=3, then load=7 written mid-run
        wr(1, 2, 3, 0);
        pulse(3'b010, 3'b000);
        tick(6);
        wr(1, 2, 7, 0);
        tick(20);
        // PWM ch2 load=9 with cmp 3, then 0, then 20
        wr(2, 3, 9, 3);
        pulse(3'b100, 3'b000);
        tick(25);
        wr(2, 3, 9, 0);
        tick(12);
        wr(2, 3, 9, 20);
        tick(12);
        pulse(3'b000, 3'b111);
        // stop freezes count at 2; start+stop together keeps IDLE
        wr(0, 2, 6, 0);
        pulse(3'b001, 3'b000);
        tick(4);
        pulse(3'b000, 3'b001);
        tick(3);
        chk("stop_frozen", 64'(bus.cnt_rd_data), 64'(2));
        pulse(3'b001, 3'b001);
        chk("startstop_idle", 64'(bus.busy[0]), 64'(0));
        // reset mid-run, then start with shadow off is ignored
        pulse(3'b111, 3'b000);
        tick(3);
        async_reset();
        pulse(3'b111, 3'b000);
        tick(2);
        chk("off_start_ignored", 64'(bus.busy), 64'(0));
`ifdef TIMER_IRQ_STICKY_EN
        wr(1, 2, 0, 0);
        pulse(3'b010, 3'b000);
        tick(2);
        bus.irq_clr = 3'b010;
        tick(3);
        chk("irq_set_wins", 64'(bus.irq_status[1]), 64'(1));
        bus.irq_clr = '0;
        pulse(3'b000, 3'b010);
        tick(1);
        bus.irq_clr = 3'b111;
        tick(2);
        chk("irq_cleared", 64'(bus.irq), 64'(0));
        bus.irq_clr = '0;
`endif
        // random traffic, including writes to the nonexistent channel 3
        repeat (600) begin
            bus.cfg_we   = $urandom_range(0, 4) == 0;
            bus.cfg_ch   = 2'($urandom_range(0, 3));
            bus.cfg_mode = 2'($urandom_range(0, 3));
            bus.cfg_load = W'($urandom_range(0, 12));
            bus.cfg_cmp  = W'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                bus.start[i] = $urandom_range(0, 9) == 0;
                bus.stop[i]  = $urandom_range(0, 19) == 0;
`ifdef TIMER_IRQ_STICKY_EN
                bus.irq_clr[i] = $urandom_range(0, 3) == 0;
`endif
            end
            tick();
        end
        bus.cfg_we = 0; bus.start = '0; bus.stop = '0;
        tick(2);
        async_reset();
        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
